// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32 core: XLEN, the 4-bit ALU op codes also used
// by the control unit, and the state encoding of the iterative divider.
package riscv_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN) + 1;

    localparam logic [3:0] ALU_DIV  = 4'b1011;
    localparam logic [3:0] ALU_DIVU = 4'b1100;
    localparam logic [3:0] ALU_REM  = 4'b1101;
    localparam logic [3:0] ALU_REMU = 4'b1110;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } div_state_t;

    function automatic logic is_div_op(input logic [3:0] code);
        return (code == ALU_DIV) || (code == ALU_DIVU) ||
               (code == ALU_REM) || (code == ALU_REMU);
    endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle, MSB first; signed ops divide magnitudes and fix signs at the end.
module div_unit #(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [3:0]      alu_control,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [1:0]      dbg_state_o
);
    import riscv_pkg::*;

    // Handshake: start is sampled only in IDLE with a valid op code and flush low;
    // busy stays high while the core must stall, done pulses once with result valid.

    div_state_t      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN:0]   rem_q;
    logic [XLEN-1:0] dvs_q;
    logic            neg_quo_q;
    logic            neg_rem_q;
    logic            is_rem_q;
    logic            busy_q;
    logic            done_q;
    logic [XLEN-1:0] result_q;

    logic            accept;
    logic            req_signed;
    logic            req_rem;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            overflow;
    logic            special;
    logic [XLEN-1:0] special_res;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   trial;
    logic            q_bit;
    logic [XLEN:0]   rem_d;
    logic [XLEN-1:0] quo_d;
    logic [XLEN-1:0] fix_quo;
    logic [XLEN-1:0] fix_rem;
    logic [XLEN-1:0] fix_res;

    always_comb begin
        accept      = start && (state_q == S_IDLE) && is_div_op(alu_control) && !flush;
        req_signed  = (alu_control == ALU_DIV) || (alu_control == ALU_REM);
        req_rem     = (alu_control == ALU_REM) || (alu_control == ALU_REMU);
        a_neg       = req_signed && src_a[XLEN-1];
        b_neg       = req_signed && src_b[XLEN-1];
        a_mag       = a_neg ? (~src_a + 1'b1) : src_a;
        b_mag       = b_neg ? (~src_b + 1'b1) : src_b;
        div_zero    = (src_b == '0);
        overflow    = req_signed && (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (src_b == '1);
        special     = div_zero || overflow;
        if (div_zero) begin
            special_res = req_rem ? src_a : '1;
        end else begin
            special_res = req_rem ? '0 : src_a;
        end
    end

    // A set top bit means the shifted partial remainder already exceeds any divisor.
    always_comb begin
        rem_sh  = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
        trial   = rem_sh - {1'b0, dvs_q};
        q_bit   = !trial[XLEN] || rem_q[XLEN];
        rem_d   = q_bit ? trial : rem_sh;
        quo_d   = {quo_q[XLEN-2:0], q_bit};
        fix_quo = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
        fix_rem = neg_rem_q ? (~rem_q[XLEN-1:0] + 1'b1) : rem_q[XLEN-1:0];
        fix_res = is_rem_q ? fix_rem : fix_quo;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_rem_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        is_rem_q  <= req_rem;
                        neg_quo_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        cnt_q     <= '0;
                        if (special) begin
                            result_q <= special_res;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            quo_q   <= a_mag;
                            rem_q   <= '0;
                            dvs_q   <= b_mag;
                            busy_q  <= 1'b1;
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        quo_q <= quo_d;
                        rem_q <= rem_d;
                        if (cnt_q == CNT_W'(XLEN - 1)) begin
                            state_q <= S_FIX;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                S_FIX: begin
                    busy_q <= 1'b0;
                    if (flush) begin
                        state_q <= S_IDLE;
                    end else begin
                        result_q <= fix_res;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: latency, busy window, results, special cases,
// ignored starts, flush and asynchronous reset.
module tb_div_unit;

    localparam logic [3:0] OP_DIV  = 4'b1011;
    localparam logic [3:0] OP_DIVU = 4'b1100;
    localparam logic [3:0] OP_REM  = 4'b1101;
    localparam logic [3:0] OP_REMU = 4'b1110;
    localparam logic [3:0] OP_NONE = 4'b0000;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  alu_control;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [1:0]  dbg_state_o;

    int total;
    int bad;

    div_unit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .alu_control (alu_control),
        .src_a       (src_a),
        .src_b       (src_b),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .dbg_state_o (dbg_state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Launch one op; optionally drive a second start at cycle dist_cyc after launch.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat,
                          input int dist_cyc, input logic [3:0] dop,
                          input logic [31:0] da, input logic [31:0] db);
        int          lat;
        int          busy_bad;
        logic [31:0] res;
        lat      = 0;
        busy_bad = 0;
        res      = '0;
        @(negedge clk);
        start       = 1'b1;
        alu_control = op;
        src_a       = a;
        src_b       = b;
        for (int cyc = 1; cyc <= 60 && lat == 0; cyc++) begin
            @(negedge clk);
            start       = 1'b0;
            alu_control = OP_NONE;
            src_a       = $urandom;
            src_b       = $urandom;
            if (cyc == dist_cyc) begin
                start       = 1'b1;
                alu_control = dop;
                src_a       = da;
                src_b       = db;
            end
            if (busy !== (cyc < exp_lat)) busy_bad++;
            if (done === 1'b1) begin
                lat = cyc;
                res = result;
            end
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_res"}, res, exp_res);
        check({tag, "_busy"}, busy_bad, 0);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_post"}, 32'({done, busy}), 32'd0);
    endtask

    initial begin
        int nd;
        int bb;
        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        start       = 1'b0;
        alu_control = OP_NONE;
        src_a       = '0;
        src_b       = '0;
        flush       = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_state", 32'(dbg_state_o), 32'd0);

        // Unsigned and signed normal ops
        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 34, 0, OP_NONE, 0, 0);
        run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 34, 0, OP_NONE, 0, 0);
        run_op("div_m20_3", OP_DIV, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 34, 0, OP_NONE, 0, 0);
        run_op("rem_m20_3", OP_REM, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 34, 0, OP_NONE, 0, 0);
        run_op("rem_20_m3", OP_REM, 32'd20, 32'hFFFF_FFFD, 32'd2, 34, 0, OP_NONE, 0, 0);
        run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 0, OP_NONE, 0, 0);
        run_op("div_min_2", OP_DIV, 32'h8000_0000, 32'd2, 32'hC000_0000, 34, 0, OP_NONE, 0, 0);
        run_op("remu_big", OP_REMU, 32'hFFFF_FFFF, 32'h10, 32'hF, 34, 0, OP_NONE, 0, 0);
        run_op("divu_min_m1", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34, 0, OP_NONE, 0, 0);

        // Special cases finish one cycle after start
        run_op("div_x_0", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, OP_NONE, 0, 0);
        run_op("remu_x_0", OP_REMU, 32'h1234, 32'd0, 32'h1234, 1, 0, OP_NONE, 0, 0);
        run_op("divu_x_0", OP_DIVU, 32'h55, 32'd0, 32'hFFFF_FFFF, 1, 0, OP_NONE, 0, 0);
        run_op("rem_x_0", OP_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1, 0, OP_NONE, 0, 0);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, OP_NONE, 0, 0);
        run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0, OP_NONE, 0, 0);

        // Starts while busy or in the done cycle are ignored
        run_op("start_mid", OP_DIVU, 32'd1000, 32'd10, 32'd100, 34, 5, OP_DIV, 32'd7, 32'd0);
        run_op("start_done", OP_DIVU, 32'd1000, 32'd10, 32'd100, 34, 34, OP_DIV, 32'd7, 32'd0);

        // Unknown op code is ignored
        @(negedge clk);
        start       = 1'b1;
        alu_control = OP_NONE;
        src_a       = 32'd9;
        src_b       = 32'd0;
        bb          = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy !== 1'b0 || done !== 1'b0) bb++;
        end
        check("bad_code", bb, 0);
        check("bad_code_res", result, 32'd100);

        // Flush during CALC
        @(negedge clk);
        start       = 1'b1;
        alu_control = OP_DIVU;
        src_a       = 32'd1000;
        src_b       = 32'd7;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) nd++;
        end
        check("flush_nodone", nd, 0);
        check("flush_res", result, 32'd100);
        run_op("after_flush", OP_DIVU, 32'd1000, 32'd7, 32'd142, 34, 0, OP_NONE, 0, 0);

        // Asynchronous reset mid-CALC
        @(negedge clk);
        start       = 1'b1;
        alu_control = OP_DIVU;
        src_a       = 32'd100;
        src_b       = 32'd7;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_res", result, 32'd0);
        check("arst_state", 32'(dbg_state_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("after_rst", OP_DIVU, 32'd100, 32'd7, 32'd14, 34, 0, OP_NONE, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
